dff_sipo_deserializer: RTL and testbench
========================================

// Module: dff_sipo_deserializer
// PURPOSE
//  Consumes the registered serial bit stream produced by the upstream D flip-flop stage (its dout).
//  Start-qualified framing assembles WIDTH consecutive valid bits into a parallel word.
//  Presents the word on a valid/ready output with a single-word holding register.
//  Flags overrun (word lost while the output is stalled) and framing error (start seen mid-frame).
// PARAMETERS
//  WIDTH      8  bits per frame/word; legal range is 2..32
//  MSB_FIRST  1  1: first bit of the frame lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//  clk        in   1      single clock; all logic is on posedge
//  rst        in   1      synchronous, active-high reset
//  sin        in   1      serial data bit from the upstream DFF output
//  sin_valid  in   1      sin is meaningful this cycle; bits with sin_valid=0 are ignored
//  sin_start  in   1      qualifies sin as bit 0 of a new frame; ignored when sin_valid=0
//  dout       out  WIDTH  assembled word, stable while dout_valid=1 and dout_ready=0
//  dout_valid out  1      dout holds an unconsumed word
//  dout_ready in   1      consumer accepts dout when dout_valid && dout_ready at posedge
//  busy       out  1      1 while a frame is partially assembled (state SHIFT)
//  overrun    out  1      one-cycle pulse: completed word dropped because the holding register was full
//  frame_err  out  1      one-cycle pulse: sin_start arrived while in SHIFT
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0
//   - rst overrides every other input. A partial frame and any held word are discarded.
//  FSM IDLE
//   - On sin_valid && sin_start: capture sin as bit 0, set count=1, go to SHIFT.
//   - Bits that arrive without start are ignored.
//  FSM SHIFT
//   - Each sin_valid captures one bit and increments count.
//   - When the WIDTH-th bit is captured: count=0, go to IDLE, issue a word-complete event in the same cycle.
//   - sin_valid && sin_start in SHIFT: abort the partial frame, pulse frame_err, capture sin as bit 0, set count=1, stay in SHIFT.
//   - sin_valid=0 gaps of any length are allowed; state and count hold.
//  Bit placement
//   - MSB_FIRST=1: shift left and insert at the LSB, so after WIDTH bits the first bit is at [WIDTH-1].
//   - MSB_FIRST=0: shift right and insert at the MSB, so the first bit is at [0].
//  Output holding register
//   - Word-complete loads dout; dout_valid=1 from the next cycle. Latency is 1 clock after the last bit's capturing edge.
//   - Accept (dout_valid && dout_ready) clears dout_valid next cycle unless a word-complete occurs in the same cycle.
//   - Accept and word-complete in the same cycle: load the new word, keep dout_valid=1, no overrun.
//   - Word-complete while dout_valid && !dout_ready: new word dropped, dout unchanged, overrun=1 for one cycle.
//   - The deserializer never stalls the input.
//   - dout_ready is ignored while dout_valid=0.
//  Status
//   - busy = (state==SHIFT), registered.
//   - overrun and frame_err are registered single-cycle pulses, 0 otherwise.
//  Boundaries
//   - Count wraps only through completion; it never exceeds WIDTH-1 while in SHIFT.
//   - With WIDTH=2, back-to-back frames are legal: the start bit is accepted in the cycle right after completion.
// STRUCTURE
//  Package dff_sipo_pkg
//   - typedef enum logic [0:0] {IDLE, SHIFT} sipo_state_t
//   - function cnt_w(width) = $clog2(width+1)
//  Sub-module sipo_out_stage (WIDTH): the holding register, the valid/ready logic and overrun generation.
//  Parent module: FSM, counter and shift register.
// TESTING (WIDTH=8, MSB_FIRST=1 unless stated)
//  1. start, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 -> dout=8'hA5, dout_valid high 1 cycle after the 8th bit, busy low after.
//  2. Same frame with MSB_FIRST=0 -> dout=8'hA5 bit-reversed = 8'hA5 is symmetric, so use bits 1,1,0,0,0,0,0,0 -> 8'h03 (MSB_FIRST=1 gives 8'hC0).
//  3. dout_ready=0, two frames 8'h3C then 8'hFF -> dout stays 8'h3C, overrun pulses once; then dout_ready=1 -> dout_valid drops next cycle.
//  4. Frame 8'h11 completes in the same cycle dout_ready accepts prior 8'h22 -> dout=8'h11, dout_valid stays 1, no overrun.
//  5. 4 bits, then start with a new frame 8'h5A -> frame_err one pulse, dout=8'h5A; also 3-cycle sin_valid=0 gaps mid-frame -> same result.
//  6. rst asserted after 5 bits with dout_valid=1 -> next cycle all outputs 0, IDLE; unqualified bits ignored until the next start.

Source files
------------

// File: rtl/dff_sipo_deserializer_pkg.sv
// Shared types and sizing helpers for the start-framed serial-to-parallel deserializer.
package dff_sipo_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} sipo_state_t;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    // Bit counter width: must hold values 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dff_sipo_deserializer_if.sv
// Serial input, parallel valid/ready output and status pulses of the deserializer.
interface dff_sipo_deserializer_if
    import dff_sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
    logic             sin;
    logic             sin_valid;
    logic             sin_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    // master: serial source plus word consumer; slave: the deserializer
    modport master (
        output sin, sin_valid, sin_start, dout_ready,
        input  dout, dout_valid, busy, overrun, frame_err
    );

    modport slave (
        input  sin, sin_valid, sin_start, dout_ready,
        output dout, dout_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/dff_sipo_deserializer_out_stage.sv
// Single-word holding register with valid/ready handshake; flags words dropped while stalled.
module sipo_out_stage
    import dff_sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word_in,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);
    logic [WIDTH-1:0] dout_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             accept;
    logic             can_load;

    assign accept   = valid_reg && dout_ready;
    // The register is free if empty or being drained in this very cycle.
    assign can_load = !valid_reg || dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= word_done && !can_load;
            if (word_done && can_load) begin
                dout_reg  <= word_in;
                valid_reg <= 1'b1;
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
    assign overrun    = overrun_reg;
endmodule

// File: rtl/dff_sipo_deserializer.sv
// Start-qualified serial-to-parallel deserializer: framing FSM, bit counter and shift register
// feeding a one-word output holding stage.
module dff_sipo_deserializer
    import dff_sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    dff_sipo_deserializer_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sipo_state_t      state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             frame_err_reg, frame_err_next;
    logic             word_done;
    logic             start_bit;

    assign start_bit = bus.sin_valid && bus.sin_start;

    // shifted: current contents with sin appended; first_word: sin alone as the frame's first bit
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_ins
                    assign shifted[gi]    = bus.sin;
                    assign first_word[gi] = bus.sin;
                end else begin : g_mov
                    assign shifted[gi]    = shift_reg[gi-1];
                    assign first_word[gi] = 1'b0;
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_ins
                    assign shifted[gi]    = bus.sin;
                    assign first_word[gi] = bus.sin;
                end else begin : g_mov
                    assign shifted[gi]    = shift_reg[gi+1];
                    assign first_word[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        frame_err_next = 1'b0;
        word_done      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_bit) begin
                    shift_next = first_word;
                    count_next = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (start_bit) begin
                    // Restart: the partial frame is thrown away.
                    frame_err_next = 1'b1;
                    shift_next     = first_word;
                    count_next     = CW'(1);
                end else if (bus.sin_valid) begin
                    shift_next = shifted;
                    if (count_reg == LAST_CNT) begin
                        count_next = '0;
                        state_next = IDLE;
                        word_done  = 1'b1;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    logic [WIDTH-1:0] dout_w;
    logic             dout_valid_w;
    logic             overrun_w;

    sipo_out_stage #(.WIDTH(WIDTH)) u_out (
        .clk        (clk),
        .rst        (rst),
        .word_done  (word_done),
        .word_in    (shift_next),
        .dout_ready (bus.dout_ready),
        .dout       (dout_w),
        .dout_valid (dout_valid_w),
        .overrun    (overrun_w)
    );

    assign bus.dout       = dout_w;
    assign bus.dout_valid = dout_valid_w;
    assign bus.overrun    = overrun_w;
    assign bus.busy       = (state_reg == SHIFT);
    assign bus.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_dff_sipo_deserializer.sv
// Scoreboard bench: two deserializers (MSB-first and LSB-first) share one serial stimulus;
// accepted words are popped from per-DUT queues of hand-computed values.
module tb_dff_sipo_deserializer;
    logic clk;
    logic rst;
    logic sin, sin_valid, sin_start, dout_ready;

    int checks   = 0;
    int failures = 0;
    int ov1 = 0, ov0 = 0, fe1 = 0, fe0 = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    logic [7:0] e1, e0;

    dff_sipo_deserializer_if #(.WIDTH(8)) bus1 ();
    dff_sipo_deserializer_if #(.WIDTH(8)) bus0 ();

    assign bus1.sin = sin;  assign bus1.sin_valid = sin_valid;
    assign bus1.sin_start = sin_start;  assign bus1.dout_ready = dout_ready;
    assign bus0.sin = sin;  assign bus0.sin_valid = sin_valid;
    assign bus0.sin_start = sin_start;  assign bus0.dout_ready = dout_ready;

    dff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: one line per accepted word, plus pulse counting.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.dout_valid && bus1.dout_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL msb_unexpected_word actual=%0h required=none", bus1.dout);
                end else begin
                    e1 = q1.pop_front();
                    $display("txn msb_first dout=%02h expected=%02h", bus1.dout, e1);
                    chk("msb_dout", 32'(bus1.dout), 32'(e1));
                end
            end
            if (bus0.dout_valid && bus0.dout_ready) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL lsb_unexpected_word actual=%0h required=none", bus0.dout);
                end else begin
                    e0 = q0.pop_front();
                    $display("txn lsb_first dout=%02h expected=%02h", bus0.dout, e0);
                    chk("lsb_dout", 32'(bus0.dout), 32'(e0));
                end
            end
            if (bus1.overrun)   ov1++;
            if (bus0.overrun)   ov0++;
            if (bus1.frame_err) fe1++;
            if (bus0.frame_err) fe0++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin = b; sin_valid = 1'b1; sin_start = st;
        @(posedge clk);
        #1;
        sin_valid = 1'b0; sin_start = 1'b0;
    endtask

    // Sends w[7] first; optional gap of gap_len idle cycles after bit index gap_after.
    task automatic send_frame(input logic [7:0] w, input int gap_after, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[7-i], i == 0);
            if (i == gap_after) idle(gap_len);
        end
    endtask

    task automatic expect_word(input logic [7:0] m, input logic [7:0] l);
        q1.push_back(m);
        q0.push_back(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; dout_ready = 1'b0;
        idle(3);
        chk("rst_dout", 32'(bus1.dout), 32'h0);
        chk("rst_valid", 32'(bus1.dout_valid), 32'h0);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        chk("rst_pulses", 32'({bus1.overrun, bus1.frame_err, bus0.overrun, bus0.frame_err}), 32'h0);
        rst = 1'b0;
        idle(1);

        // 1: basic frame A5, latency and busy
        dout_ready = 1'b1;
        expect_word(8'hA5, 8'hA5);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) send_bit(w[7-i], i == 0);
        chk("t1_valid_before_last", 32'(bus1.dout_valid), 32'h0);
        chk("t1_busy_mid", 32'(bus1.busy), 32'h1);
        send_bit(w[0], 1'b0);
        chk("t1_valid_after_last", 32'(bus1.dout_valid), 32'h1);
        chk("t1_busy_after", 32'(bus1.busy), 32'h0);
        idle(2);

        // 2: bit order, 1,1,0,0,0,0,0,0
        expect_word(8'hC0, 8'h03);
        send_frame(8'hC0, -1, 0);
        idle(2);

        // 3: stalled output, second word dropped
        dout_ready = 1'b0;
        expect_word(8'h3C, 8'h3C);
        send_frame(8'h3C, -1, 0);
        idle(1);
        send_frame(8'hFF, -1, 0);
        idle(2);
        chk("t3_overrun_msb", 32'(ov1), 32'd1);
        chk("t3_overrun_lsb", 32'(ov0), 32'd1);
        chk("t3_dout_held", 32'(bus1.dout), 32'h3C);
        dout_ready = 1'b1;
        idle(1);
        chk("t3_valid_dropped", 32'(bus1.dout_valid), 32'h0);
        idle(1);

        // 4: completion in the same cycle as accept
        dout_ready = 1'b0;
        expect_word(8'h22, 8'h44);
        send_frame(8'h22, -1, 0);
        w = 8'h11;
        for (int i = 0; i < 7; i++) send_bit(w[7-i], i == 0);
        expect_word(8'h11, 8'h88);
        dout_ready = 1'b1;
        send_bit(w[0], 1'b0);
        chk("t4_valid_kept", 32'(bus1.dout_valid), 32'h1);
        chk("t4_dout_new", 32'(bus1.dout), 32'h11);
        idle(2);
        chk("t4_no_overrun", 32'(ov1), 32'd1);
        chk("t4_valid_clear", 32'(bus1.dout_valid), 32'h0);

        // 5: restart mid-frame, then again with idle gaps
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        expect_word(8'h5A, 8'h5A);
        send_frame(8'h5A, -1, 0);
        idle(2);
        chk("t5_frame_err_msb", 32'(fe1), 32'd1);
        chk("t5_frame_err_lsb", 32'(fe0), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, i == 0);
        expect_word(8'h5A, 8'h5A);
        send_frame(8'h5A, 2, 3);
        idle(2);
        chk("t5_frame_err_gaps", 32'(fe1), 32'd2);

        // 6: reset with a held word and a partial frame
        dout_ready = 1'b0;
        send_frame(8'h0F, -1, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        chk("t6_busy_pre", 32'(bus1.busy), 32'h1);
        chk("t6_valid_pre", 32'(bus1.dout_valid), 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_dout_rst", 32'(bus1.dout), 32'h0);
        chk("t6_valid_rst", 32'(bus1.dout_valid), 32'h0);
        chk("t6_busy_rst", 32'(bus1.busy), 32'h0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("t6_unqualified_busy", 32'(bus1.busy), 32'h0);
        chk("t6_unqualified_valid", 32'(bus0.dout_valid), 32'h0);
        dout_ready = 1'b1;
        expect_word(8'h96, 8'h69);
        send_frame(8'h96, -1, 0);

        for (int n = 0; n < 50 && (q1.size() != 0 || q0.size() != 0); n++) idle(1);
        chk("drain_msb", 32'(q1.size()), 32'd0);
        chk("drain_lsb", 32'(q0.size()), 32'd0);
        chk("final_overrun_total", 32'(ov1 + ov0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
